// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem request, one skid entry, redirect flush.
// Define FETCH_STATS_EN to add the fetch_count / flush_count statistics outputs.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h8002_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc,
    output logic [31:0] insn,
    output logic        insn_valid
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] flush_count
`endif
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DRAIN
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
    logic              imem_req_q, imem_req_d;
    logic [XLEN-1:0]   imem_addr_q, imem_addr_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   insn_q, insn_d;
    logic              insn_valid_q, insn_valid_d;
    logic              pend_valid_q, pend_valid_d;
    logic [XLEN-1:0]   pend_pc_q, pend_pc_d;
    logic [XLEN-1:0]   pend_insn_q, pend_insn_d;

    logic              consume;
    logic              out_free;
    logic              redirect_act;

    assign consume      = insn_valid_q && !stall;
    assign out_free     = !insn_valid_q || !stall;
    assign redirect_act = redirect && (state_q != S_IDLE);

    // Next-state, output-register and skid-buffer update.
    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        pc_d         = pc_q;
        insn_d       = insn_q;
        insn_valid_d = insn_valid_q;
        pend_valid_d = pend_valid_q;
        pend_pc_d    = pend_pc_q;
        pend_insn_d  = pend_insn_q;

        if (consume) begin
            insn_valid_d = 1'b0;
            insn_d       = '0;
        end

        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ:  state_d = S_WAIT;
            S_WAIT: begin
                if (imem_ack) begin
                    fetch_pc_d = fetch_pc_q + PC_STEP;
                    if (out_free) begin
                        pc_d         = fetch_pc_q;
                        insn_d       = imem_rdata;
                        insn_valid_d = 1'b1;
                        state_d      = S_REQ;
                    end else begin
                        pend_valid_d = 1'b1;
                        pend_pc_d    = fetch_pc_q;
                        pend_insn_d  = imem_rdata;
                        state_d      = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (out_free) begin
                    pc_d         = pend_pc_q;
                    insn_d       = pend_insn_q;
                    insn_valid_d = 1'b1;
                    pend_valid_d = 1'b0;
                    state_d      = S_REQ;
                end
            end
            S_DRAIN: begin
                if (imem_ack) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Redirect wins over everything; an ack in the same cycle still retires the request.
        if (redirect_act) begin
            fetch_pc_d   = {redirect_pc[XLEN-1:2], 2'b00};
            insn_valid_d = 1'b0;
            insn_d       = '0;
            pend_valid_d = 1'b0;
            case (state_q)
                S_REQ:   state_d = S_DRAIN;
                S_WAIT:  state_d = imem_ack ? S_REQ : S_DRAIN;
                S_HOLD:  state_d = S_REQ;
                S_DRAIN: state_d = imem_ack ? S_REQ : S_DRAIN;
                default: state_d = state_q;
            endcase
        end
    end

    // Request pulse is registered so it is high for exactly the REQ cycle.
    always_comb begin
        imem_req_d  = (state_d == S_REQ);
        imem_addr_d = imem_req_d ? fetch_pc_d : '0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            fetch_pc_q   <= RESET_PC;
            imem_req_q   <= 1'b0;
            imem_addr_q  <= '0;
            pc_q         <= '0;
            insn_q       <= '0;
            insn_valid_q <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_pc_q    <= '0;
            pend_insn_q  <= '0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            imem_req_q   <= imem_req_d;
            imem_addr_q  <= imem_addr_d;
            pc_q         <= pc_d;
            insn_q       <= insn_d;
            insn_valid_q <= insn_valid_d;
            pend_valid_q <= pend_valid_d;
            pend_pc_q    <= pend_pc_d;
            pend_insn_q  <= pend_insn_d;
        end
    end

    assign imem_req   = imem_req_q;
    assign imem_addr  = imem_addr_q;
    assign pc         = pc_q;
    assign insn       = insn_q;
    assign insn_valid = insn_valid_q;

`ifdef FETCH_STATS_EN
    logic [XLEN-1:0] fetch_count_q, fetch_count_d;
    logic [XLEN-1:0] flush_count_q, flush_count_d;
    logic            req_outstanding;
    logic            flush_hit;

    assign req_outstanding = (state_q == S_REQ) || (state_q == S_WAIT) || (state_q == S_DRAIN);
    assign flush_hit       = redirect_act && (insn_valid_q || pend_valid_q || req_outstanding);

    // A flush counts once per redirect cycle that actually throws work away.
    always_comb begin
        fetch_count_d = fetch_count_q;
        flush_count_d = flush_count_q;
        if (consume) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end
        if (flush_hit) begin
            flush_count_d = flush_count_q + 32'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fetch_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            fetch_count_q <= fetch_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
    assign flush_count = flush_count_q;
`endif

endmodule
